line_draw_scheduler: RTL and testbench

LINE_DRAW_SCHEDULER -- requirements
Module: line_draw_scheduler

---
 rtl/line_draw_scheduler.sv | 162 ++++++++++++++++
 tb/tb_line_draw_scheduler.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_draw_scheduler.sv
// Arbitrates two line-draw requesters and a full-screen clear onto one frame-buffer write port.
// Grant/ack and pixel pass-through are same-cycle; requesters wait (req held) while busy.
module line_draw_scheduler #(
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clean,
  input  logic [1:0]  req,
  input  logic [19:0] req_x0,
  input  logic [19:0] req_x1,
  input  logic [17:0] req_y0,
  input  logic [17:0] req_y1,
  input  logic [1:0]  req_color,
  output logic [1:0]  ack,
  output logic        ld_start,
  output logic [9:0]  ld_x0,
  output logic [9:0]  ld_x1,
  output logic [8:0]  ld_y0,
  output logic [8:0]  ld_y1,
  input  logic        ld_valid,
  input  logic [9:0]  ld_x,
  input  logic [8:0]  ld_y,
  input  logic        ld_done,
  output logic [9:0]  pixel_x,
  output logic [8:0]  pixel_y,
  output logic        pixel_color,
  output logic        pixel_we,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_START = 2'd2,
    S_DRAW  = 2'd3
  } state_t;

  localparam logic [9:0] LP_X_LAST = 10'(H_RES - 1);
  localparam logic [8:0] LP_Y_LAST = 9'(V_RES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_pend_clr;
  logic        r_ptr;
  logic        r_color;
  logic [9:0]  r_cx;
  logic [8:0]  r_cy;
  logic [9:0]  r_ld_x0;
  logic [9:0]  r_ld_x1;
  logic [8:0]  r_ld_y0;
  logic [8:0]  r_ld_y1;
  logic        w_clr_req;
  logic        w_clr_last;
  logic        w_grant;
  logic        w_grant_vld;

  // A clean arriving in the same IDLE cycle as a req must still win.
  assign w_clr_req   = r_pend_clr | clean;
  assign w_clr_last  = (r_state == S_CLEAR) && (r_cx == LP_X_LAST) && (r_cy == LP_Y_LAST);
  assign w_grant     = req[r_ptr] ? r_ptr : ~r_ptr;
  assign w_grant_vld = (r_state == S_IDLE) && !reset && !w_clr_req && (req != 2'b00);

  assign ld_x0 = r_ld_x0;
  assign ld_x1 = r_ld_x1;
  assign ld_y0 = r_ld_y0;
  assign ld_y1 = r_ld_y1;
  assign busy  = (r_state != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    ack         = 2'b00;
    ld_start    = 1'b0;
    pixel_we    = 1'b0;
    pixel_x     = 10'd0;
    pixel_y     = 9'd0;
    pixel_color = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_clr_req) begin
          w_state_nxt = S_CLEAR;
        end else if (w_grant_vld) begin
          w_state_nxt = S_START;
          ack         = w_grant ? 2'b10 : 2'b01;
        end
      end
      S_CLEAR: begin
        pixel_we = 1'b1;
        pixel_x  = r_cx;
        pixel_y  = r_cy;
        if (w_clr_last) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_START: begin
        ld_start    = 1'b1;
        w_state_nxt = S_DRAW;
      end
      S_DRAW: begin
        if (ld_valid) begin
          pixel_we    = 1'b1;
          pixel_x     = ld_x;
          pixel_y     = ld_y;
          pixel_color = r_color;
        end
        if (ld_done) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend_clr <= 1'b0;
      r_ptr      <= 1'b0;
      r_color    <= 1'b0;
      r_cx       <= 10'd0;
      r_cy       <= 9'd0;
      r_ld_x0    <= 10'd0;
      r_ld_x1    <= 10'd0;
      r_ld_y0    <= 9'd0;
      r_ld_y1    <= 9'd0;
    end else begin
      // Completion wins over a clean seen during the sweep, so it is absorbed.
      if (w_clr_last) begin
        r_pend_clr <= 1'b0;
      end else if (clean) begin
        r_pend_clr <= 1'b1;
      end

      if (w_grant_vld) begin
        r_ptr   <= ~w_grant;
        r_color <= req_color[w_grant];
        r_ld_x0 <= w_grant ? req_x0[19:10] : req_x0[9:0];
        r_ld_x1 <= w_grant ? req_x1[19:10] : req_x1[9:0];
        r_ld_y0 <= w_grant ? req_y0[17:9]  : req_y0[8:0];
        r_ld_y1 <= w_grant ? req_y1[17:9]  : req_y1[8:0];
      end

      if (r_state == S_CLEAR) begin
        if (r_cx == LP_X_LAST) begin
          r_cx <= 10'd0;
          r_cy <= w_clr_last ? 9'd0 : r_cy + 9'd1;
        end else begin
          r_cx <= r_cx + 10'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_line_draw_scheduler.sv
// Self-checking bench for line_draw_scheduler on a reduced 120x6 screen so sweeps stay short.
module tb_line_draw_scheduler;

  localparam int H = 120;
  localparam int V = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clean = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [19:0] req_x0, req_x1;
  logic [17:0] req_y0, req_y1;
  logic [1:0]  req_color;
  logic [1:0]  ack;
  logic        ld_start;
  logic [9:0]  ld_x0, ld_x1;
  logic [8:0]  ld_y0, ld_y1;
  logic        ld_valid = 1'b0;
  logic [9:0]  ld_x = 10'd0;
  logic [8:0]  ld_y = 9'd0;
  logic        ld_done = 1'b0;
  logic [9:0]  pixel_x;
  logic [8:0]  pixel_y;
  logic        pixel_color, pixel_we, busy;

  // Requester-side command data
  logic [9:0]  c_x0 [2];
  logic [9:0]  c_x1 [2];
  logic [8:0]  c_y0 [2];
  logic [8:0]  c_y1 [2];
  logic [1:0]  c_col;

  // Reference model state: round-robin pointer and the command last granted
  int          m_ptr;
  logic [9:0]  l_x0, l_x1;
  logic [8:0]  l_y0, l_y1;
  logic        l_col;

  int errors = 0;
  int checks = 0;

  assign req_x0    = {c_x0[1], c_x0[0]};
  assign req_x1    = {c_x1[1], c_x1[0]};
  assign req_y0    = {c_y0[1], c_y0[0]};
  assign req_y1    = {c_y1[1], c_y1[0]};
  assign req_color = c_col;

  always #5 clk = ~clk;

  line_draw_scheduler #(.H_RES(H), .V_RES(V)) dut (
    .clk(clk), .reset(reset), .clean(clean), .req(req),
    .req_x0(req_x0), .req_x1(req_x1), .req_y0(req_y0), .req_y1(req_y1),
    .req_color(req_color), .ack(ack), .ld_start(ld_start),
    .ld_x0(ld_x0), .ld_x1(ld_x1), .ld_y0(ld_y0), .ld_y1(ld_y1),
    .ld_valid(ld_valid), .ld_x(ld_x), .ld_y(ld_y), .ld_done(ld_done),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_color(pixel_color),
    .pixel_we(pixel_we), .busy(busy)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog expired");
  end

  task automatic set_cmd(input int i, input int x0, input int x1, input int y0, input int y1, input int col);
    c_x0[i]  = 10'(x0);
    c_x1[i]  = 10'(x1);
    c_y0[i]  = 9'(y0);
    c_y1[i]  = 9'(y1);
    c_col[i] = col[0];
  endtask

  task automatic rand_cmd(input int i);
    int x0;
    x0 = int'($urandom_range(0, 600));
    set_cmd(i, x0, x0 + int'($urandom_range(0, 11)), int'($urandom_range(0, 479)),
            int'($urandom_range(0, 479)), int'($urandom_range(0, 1)));
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    req = 2'b00; clean = 1'b0; ld_valid = 1'b0; ld_done = 1'b0;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    m_ptr = 0;
  endtask

  // IDLE cycle presenting reqv; the model decides who must be acked.
  task automatic cmd_cycle(input logic [1:0] reqv, output int g);
    int         ge;
    logic [1:0] ea;
    @(negedge clk);
    req = reqv; clean = 1'b0; ld_valid = 1'b0; ld_done = 1'b0;
    #2;
    ge = reqv[m_ptr] ? m_ptr : 1 - m_ptr;
    ea = (ge == 1) ? 2'b10 : 2'b01;
    checks++;
    if (ack !== ea) begin
      errors++;
      $display("FAIL grant_ack: ack=%b expected=%b (req=%b)", ack, ea, reqv);
    end
    checks++;
    if (busy !== 1'b0 || ld_start !== 1'b0) begin
      errors++;
      $display("FAIL idle_outputs: busy=%b ld_start=%b expected 0 0", busy, ld_start);
    end
    m_ptr = 1 - ge;
    g     = ge;
    l_x0 = c_x0[ge]; l_x1 = c_x1[ge]; l_y0 = c_y0[ge]; l_y1 = c_y1[ge]; l_col = c_col[ge];
  endtask

  // START cycle then a drawer model streaming x0..x1 along y0, optional idle gaps and one clean pulse.
  task automatic draw_line(input logic [1:0] req_next, input int clean_k, input bit gaps);
    int  n, k, bad, wr, gl;
    bit  cdone;
    @(negedge clk);
    req = req_next; clean = 1'b0; ld_valid = 1'b0; ld_done = 1'b0;
    #2;
    checks++;
    if (ld_start !== 1'b1 || busy !== 1'b1 || ack !== 2'b00 || pixel_we !== 1'b0) begin
      errors++;
      $display("FAIL start_cycle: ld_start=%b busy=%b ack=%b we=%b expected 1 1 00 0",
               ld_start, busy, ack, pixel_we);
    end
    checks++;
    if ({ld_x0, ld_x1, ld_y0, ld_y1} !== {l_x0, l_x1, l_y0, l_y1}) begin
      errors++;
      $display("FAIL endpoints: got (%0d,%0d)->(%0d,%0d) expected (%0d,%0d)->(%0d,%0d)",
               ld_x0, ld_y0, ld_x1, ld_y1, l_x0, l_y0, l_x1, l_y1);
    end
    n = int'(l_x1) - int'(l_x0) + 1;
    k = 0; bad = 0; wr = 0; gl = gaps ? 6 : 0; cdone = 0;
    while (k < n) begin
      @(negedge clk);
      clean = (k == clean_k) && !cdone;
      if (clean) cdone = 1;
      if (gl > 0 && $urandom_range(0, 3) == 0) begin
        gl--;
        ld_valid = 1'b0; ld_done = 1'b0;
        ld_x = 10'($urandom); ld_y = 9'($urandom);
        #2;
        if (pixel_we !== 1'b0 || pixel_x !== 10'd0 || pixel_y !== 9'd0 || pixel_color !== 1'b0)
          bad++;
      end else begin
        ld_valid = 1'b1;
        ld_x = l_x0 + 10'(k);
        ld_y = l_y0;
        ld_done = (k == n - 1);
        #2;
        if (pixel_we === 1'b1) wr++;
        if (pixel_we !== 1'b1 || pixel_x !== l_x0 + 10'(k) || pixel_y !== l_y0 ||
            pixel_color !== l_col)
          bad++;
        k++;
      end
      if (busy !== 1'b1 || ack !== 2'b00 || ld_start !== 1'b0 ||
          {ld_x0, ld_x1, ld_y0, ld_y1} !== {l_x0, l_x1, l_y0, l_y1})
        bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL line_pixels: %0d bad cycles, expected 0", bad);
    end
    checks++;
    if (wr != n) begin
      errors++;
      $display("FAIL line_writes: %0d writes, expected %0d", wr, n);
    end
  endtask

  // Expects the next cycle to be the first sweep cycle; row-major order, black.
  task automatic do_sweep(input int clean_at);
    int bad, wr, lx, ly;
    bad = 0; wr = 0; lx = -1; ly = -1;
    for (int i = 0; i < H * V; i++) begin
      @(negedge clk);
      clean = (i == clean_at); ld_valid = 1'b0; ld_done = 1'b0;
      #2;
      if (pixel_we === 1'b1) wr++;
      if (pixel_we !== 1'b1 || pixel_x !== 10'(i % H) || pixel_y !== 9'(i / H) ||
          pixel_color !== 1'b0 || busy !== 1'b1 || ack !== 2'b00)
        bad++;
      lx = int'(pixel_x); ly = int'(pixel_y);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL sweep_pixels: %0d bad cycles, expected 0", bad);
    end
    checks++;
    if (wr != H * V) begin
      errors++;
      $display("FAIL sweep_writes: %0d writes, expected %0d", wr, H * V);
    end
    checks++;
    if (lx != H - 1 || ly != V - 1) begin
      errors++;
      $display("FAIL sweep_last: last pixel (%0d,%0d), expected (%0d,%0d)", lx, ly, H - 1, V - 1);
    end
  endtask

  task automatic idle_no_grant(input logic [1:0] reqv);
    @(negedge clk);
    req = reqv; clean = 1'b0; ld_valid = 1'b0; ld_done = 1'b0;
    #2;
    checks++;
    if (ack !== 2'b00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL clear_priority: ack=%b busy=%b expected 00 0", ack, busy);
    end
  endtask

  task automatic test_reset();
    req = 2'b11;
    set_cmd(0, 10, 20, 5, 5, 1);
    set_cmd(1, 30, 40, 6, 6, 1);
    #2;
    checks++;
    if (ack !== 2'b00 || busy !== 1'b0 || pixel_we !== 1'b0 || ld_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: ack=%b busy=%b we=%b ld_start=%b expected 00 0 0 0",
               ack, busy, pixel_we, ld_start);
    end
    checks++;
    if ({ld_x0, ld_x1, ld_y0, ld_y1} !== 38'd0 || pixel_x !== 10'd0 || pixel_y !== 9'd0) begin
      errors++;
      $display("FAIL reset_regs: ld=%h px=%0d py=%0d expected all 0",
               {ld_x0, ld_x1, ld_y0, ld_y1}, pixel_x, pixel_y);
    end
    @(negedge clk);
    reset = 1'b0; req = 2'b00;
    m_ptr = 0;
  endtask

  task automatic test_single_line();
    int g;
    set_cmd(0, 10, 240, 10, 10, 1);
    cmd_cycle(2'b01, g);
    draw_line(2'b00, -1, 1'b0);
    idle_no_grant(2'b00);
  endtask

  task automatic test_round_robin();
    int         g;
    logic [1:0] order [3];
    order[0] = 2'b01; order[1] = 2'b10; order[2] = 2'b01;
    pulse_reset();
    set_cmd(0, 100, 104, 20, 20, 1);
    set_cmd(1, 200, 203, 30, 30, 0);
    for (int i = 0; i < 3; i++) begin
      cmd_cycle(2'b11, g);
      checks++;
      if (((g == 1) ? 2'b10 : 2'b01) !== order[i]) begin
        errors++;
        $display("FAIL rr_order: command %0d granted %0d, expected ack %b", i, g, order[i]);
      end
      draw_line(2'b11, -1, 1'b1);
      set_cmd(g, 50 + 7 * i, 55 + 7 * i, 40 + i, 40 + i, i % 2);
    end
  endtask

  task automatic test_clear_priority();
    int g;
    set_cmd(0, 300, 305, 100, 100, 1);
    @(negedge clk);
    req = 2'b01; clean = 1'b1;
    #2;
    checks++;
    if (ack !== 2'b00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL clean_beats_req: ack=%b busy=%b expected 00 0", ack, busy);
    end
    do_sweep(-1);
    cmd_cycle(2'b01, g);
    draw_line(2'b00, -1, 1'b0);
  endtask

  task automatic test_clean_mid_draw();
    int g;
    set_cmd(0, 400, 411, 200, 201, 1);
    set_cmd(1, 500, 503, 300, 300, 1);
    cmd_cycle(2'b01, g);
    draw_line(2'b10, 3, 1'b0);
    idle_no_grant(2'b10);
    do_sweep(50);
    cmd_cycle(2'b10, g);
    draw_line(2'b00, -1, 1'b0);
  endtask

  task automatic test_reset_mid_clear();
    int tgt, bad, g;
    tgt = 3 * H + 100;
    bad = 0;
    @(negedge clk);
    req = 2'b00; clean = 1'b1;
    #2;
    for (int i = 0; i <= tgt; i++) begin
      @(negedge clk);
      clean = 1'b0;
      #2;
      if (pixel_we !== 1'b1 || pixel_x !== 10'(i % H) || pixel_y !== 9'(i / H)) bad++;
    end
    checks++;
    if (bad != 0 || pixel_x !== 10'd100 || pixel_y !== 9'd3) begin
      errors++;
      $display("FAIL sweep_to_100_3: bad=%0d at (%0d,%0d), expected 0 at (100,3)", bad, pixel_x, pixel_y);
    end
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (pixel_we !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: we=%b busy=%b expected 0 0", pixel_we, busy);
    end
    @(negedge clk);
    reset = 1'b0;
    m_ptr = 0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #2;
      if (busy !== 1'b0 || pixel_we !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL no_resume: %0d busy cycles after reset, expected 0", bad);
    end
    set_cmd(0, 5, 8, 1, 1, 1);
    set_cmd(1, 9, 12, 2, 2, 0);
    cmd_cycle(2'b11, g);
    draw_line(2'b00, -1, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [1:0] want;
    int         g, ck;
    rand_cmd(0);
    rand_cmd(1);
    want = 2'b11;
    for (int it = 0; it < 24; it++) begin
      if (want == 2'b00) want = 2'($urandom_range(1, 3));
      cmd_cycle(want, g);
      want[g] = 1'($urandom_range(0, 1));
      ck = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, int'(l_x1 - l_x0))) : -1;
      draw_line(want, ck, 1'b1);
      rand_cmd(g);
      if (ck >= 0) begin
        idle_no_grant(want);
        do_sweep(-1);
      end
    end
  endtask

  initial begin
    m_ptr = 0;
    test_reset();
    test_single_line();
    test_round_robin();
    test_clear_priority();
    test_clean_mid_draw();
    test_reset_mid_clear();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
